// File: rtl/proc_pkg.sv
// Shared constants for the processor tile issue stage: opcodes, source
// selectors, FSM encoding and default instruction field positions.
package proc_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_OR  = 2'd3;

  localparam logic [1:0] SRC_INT  = 2'd0;
  localparam logic [1:0] SRC_NIN  = 2'd1;
  localparam logic [1:0] SRC_ACC  = 2'd2;
  localparam logic [1:0] SRC_ZERO = 2'd3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH0 = 3'd1;
  localparam logic [2:0] ST_FETCH1 = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;

  // Field positions for the default 8-bit instruction layout.
  localparam int OP_MSB   = 7;
  localparam int OP_LSB   = 6;
  localparam int SRC0_MSB = 5;
  localparam int SRC0_LSB = 4;
  localparam int SRC1_MSB = 3;
  localparam int SRC1_LSB = 2;
  localparam int DST0_BIT = 1;
  localparam int DST1_BIT = 0;

endpackage

// File: rtl/proc_operand_sel.sv
// Combinational operand mux: picks int FIFO, nin FIFO, accumulator or zero and
// reports whether that source can supply a value this cycle.
module proc_operand_sel
  import proc_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic [1:0]            sel,
  input  logic                  int_empty,
  input  logic [DATA_WIDTH-1:0] int_data,
  input  logic                  nin_empty,
  input  logic [DATA_WIDTH-1:0] nin_data,
  input  logic [DATA_WIDTH-1:0] acc,
  output logic [DATA_WIDTH-1:0] operand,
  output logic                  avail,
  output logic                  int_req,
  output logic                  nin_req
);

  always_comb begin
    operand = '0;
    avail   = 1'b1;
    int_req = 1'b0;
    nin_req = 1'b0;
    case (sel)
      SRC_INT: begin
        operand = int_data;
        avail   = !int_empty;
        int_req = 1'b1;
      end
      SRC_NIN: begin
        operand = nin_data;
        avail   = !nin_empty;
        nin_req = 1'b1;
      end
      SRC_ACC:  operand = acc;
      default:  operand = '0;
    endcase
  end

endmodule

// File: rtl/proc_issue_ctrl.sv
// Issue/sequencing stage: IDLE -> FETCH0 -> FETCH1 -> EXEC -> WRITE, one instruction at a time.
// Optional perf counters via PROC_ISSUE_PERF_CNT_EN. Handshake: all FIFOs are FWFT; a deq/enq
// strobe is a single-cycle pulse asserted only when the source is non-empty / sink is not full.
module proc_issue_ctrl
  import proc_pkg::*;
#(
  parameter int DATA_WIDTH     = 4,
  parameter int INST_WIDTH     = 8,
  parameter int OPCODE_WIDTH   = 2,
  parameter int SRC0_IDX_WIDTH = 2,
  parameter int SRC1_IDX_WIDTH = 2,
  parameter int DST0_IDX_WIDTH = 1,
  parameter int DST1_IDX_WIDTH = 1,
  parameter int PERF_CNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ctrl_fifo_empty,
  input  logic [INST_WIDTH-1:0]   ctrl_fifo_data_out,
  output logic                    ctrl_fifo_deq,
  input  logic                    int_fifo_empty,
  input  logic [DATA_WIDTH-1:0]   int_fifo_data_out,
  output logic                    int_fifo_deq,
  input  logic                    nin_fifo_empty,
  input  logic [DATA_WIDTH-1:0]   nin_fifo_data_out,
  output logic                    nin_fifo_deq,
  input  logic                    nout_fifo_full,
  output logic                    nout_fifo_enq,
  output logic [DATA_WIDTH-1:0]   nout_fifo_data_in,
  input  logic                    bus_fifo_full,
  output logic                    bus_fifo_enq,
  output logic [DATA_WIDTH-1:0]   bus_fifo_data_in,
  output logic                    alu_enable,
  output logic [OPCODE_WIDTH-1:0] alu_op_code,
  output logic [DATA_WIDTH-1:0]   alu_op0,
  output logic [DATA_WIDTH-1:0]   alu_op1,
  input  logic [DATA_WIDTH-1:0]   alu_out,
  output logic                    busy,
  output logic [2:0]              fsm_state
`ifdef PROC_ISSUE_PERF_CNT_EN
  ,
  output logic [PERF_CNT_WIDTH-1:0] retired_cnt,
  output logic [PERF_CNT_WIDTH-1:0] stall_cnt
`endif
);

  localparam int DST1_POS  = 0;
  localparam int DST0_POS  = DST1_POS + DST1_IDX_WIDTH;
  localparam int SRC1_POS  = DST0_POS + DST0_IDX_WIDTH;
  localparam int SRC0_POS  = SRC1_POS + SRC1_IDX_WIDTH;
  localparam int OP_POS    = SRC0_POS + SRC0_IDX_WIDTH;

  logic [2:0]              state_r, state_nx;
  logic [INST_WIDTH-1:0]   inst_r;
  logic [DATA_WIDTH-1:0]   op0_r, op1_r, result_r, acc_r;
  logic [OPCODE_WIDTH-1:0] op_f;
  logic [1:0]              src0_f, src1_f, cur_sel;
  logic                    dst0_f, dst1_f;
  logic [DATA_WIDTH-1:0]   operand;
  logic                    src_avail, int_req, nin_req;
  logic                    in_fetch, fetch_go, write_ready;

  assign op_f   = inst_r[OP_POS +: OPCODE_WIDTH];
  assign src0_f = inst_r[SRC0_POS +: SRC0_IDX_WIDTH];
  assign src1_f = inst_r[SRC1_POS +: SRC1_IDX_WIDTH];
  assign dst0_f = inst_r[DST0_POS];
  assign dst1_f = inst_r[DST1_POS];

  // One shared selector; FETCH1 simply re-points it at src1.
  assign cur_sel  = (state_r == ST_FETCH1) ? src1_f : src0_f;
  assign in_fetch = (state_r == ST_FETCH0) || (state_r == ST_FETCH1);
  assign fetch_go = in_fetch && src_avail;
  assign write_ready = (!dst0_f || !nout_fifo_full) && (!dst1_f || !bus_fifo_full);

  proc_operand_sel #(.DATA_WIDTH(DATA_WIDTH)) u_operand_sel (
    .sel       (cur_sel),
    .int_empty (int_fifo_empty),
    .int_data  (int_fifo_data_out),
    .nin_empty (nin_fifo_empty),
    .nin_data  (nin_fifo_data_out),
    .acc       (acc_r),
    .operand   (operand),
    .avail     (src_avail),
    .int_req   (int_req),
    .nin_req   (nin_req)
  );

  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE:   if (!ctrl_fifo_empty) state_nx = ST_FETCH0;
      ST_FETCH0: if (src_avail) state_nx = ST_FETCH1;
      ST_FETCH1: if (src_avail) state_nx = ST_EXEC;
      ST_EXEC:   state_nx = ST_WRITE;
      ST_WRITE:  if (write_ready) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      inst_r   <= '0;
      op0_r    <= '0;
      op1_r    <= '0;
      result_r <= '0;
      acc_r    <= '0;
    end else begin
      state_r <= state_nx;
      if (state_r == ST_IDLE && !ctrl_fifo_empty) inst_r <= ctrl_fifo_data_out;
      if (state_r == ST_FETCH0 && src_avail) op0_r <= operand;
      if (state_r == ST_FETCH1 && src_avail) op1_r <= operand;
      if (state_r == ST_EXEC) begin
        result_r <= alu_out;
        acc_r    <= alu_out;
      end
    end
  end

  // Strobes are forced low during reset so an aborted instruction consumes nothing more.
  assign ctrl_fifo_deq = !reset && (state_r == ST_IDLE) && !ctrl_fifo_empty;
  assign int_fifo_deq  = !reset && fetch_go && int_req;
  assign nin_fifo_deq  = !reset && fetch_go && nin_req;
  assign nout_fifo_enq = !reset && (state_r == ST_WRITE) && write_ready && dst0_f;
  assign bus_fifo_enq  = !reset && (state_r == ST_WRITE) && write_ready && dst1_f;

  assign nout_fifo_data_in = (state_r == ST_WRITE) ? result_r : '0;
  assign bus_fifo_data_in  = (state_r == ST_WRITE) ? result_r : '0;

  assign alu_enable  = (state_r == ST_EXEC);
  assign alu_op_code = alu_enable ? op_f  : '0;
  assign alu_op0     = alu_enable ? op0_r : '0;
  assign alu_op1     = alu_enable ? op1_r : '0;

  assign busy      = (state_r != ST_IDLE);
  assign fsm_state = state_r;

`ifdef PROC_ISSUE_PERF_CNT_EN
  logic stalled;
  assign stalled = (in_fetch && !src_avail) || (state_r == ST_WRITE && !write_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (state_r == ST_WRITE && write_ready && retired_cnt != '1) retired_cnt <= retired_cnt + 1'b1;
      if (stalled && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_proc_issue_ctrl.sv
// Bench for proc_issue_ctrl: FWFT FIFO models as queues, a small ALU model,
// a table of single-instruction vectors plus hand-written stall/reset sequences.
module tb_proc_issue_ctrl;
  import proc_pkg::*;

  localparam int DW = 4;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          ctrl_fifo_empty, ctrl_fifo_deq;
  logic [IW-1:0] ctrl_fifo_data_out;
  logic          int_fifo_empty, int_fifo_deq;
  logic [DW-1:0] int_fifo_data_out;
  logic          nin_fifo_empty, nin_fifo_deq;
  logic [DW-1:0] nin_fifo_data_out;
  logic          nout_fifo_full, nout_fifo_enq;
  logic [DW-1:0] nout_fifo_data_in;
  logic          bus_fifo_full, bus_fifo_enq;
  logic [DW-1:0] bus_fifo_data_in;
  logic          alu_enable;
  logic [1:0]    alu_op_code;
  logic [DW-1:0] alu_op0, alu_op1, alu_out;
  logic          busy;
  logic [2:0]    fsm_state;
`ifdef PROC_ISSUE_PERF_CNT_EN
  logic [15:0]   retired_cnt, stall_cnt;
`endif

  proc_issue_ctrl dut (
    .clk(clk), .reset(reset),
    .ctrl_fifo_empty(ctrl_fifo_empty), .ctrl_fifo_data_out(ctrl_fifo_data_out), .ctrl_fifo_deq(ctrl_fifo_deq),
    .int_fifo_empty(int_fifo_empty), .int_fifo_data_out(int_fifo_data_out), .int_fifo_deq(int_fifo_deq),
    .nin_fifo_empty(nin_fifo_empty), .nin_fifo_data_out(nin_fifo_data_out), .nin_fifo_deq(nin_fifo_deq),
    .nout_fifo_full(nout_fifo_full), .nout_fifo_enq(nout_fifo_enq), .nout_fifo_data_in(nout_fifo_data_in),
    .bus_fifo_full(bus_fifo_full), .bus_fifo_enq(bus_fifo_enq), .bus_fifo_data_in(bus_fifo_data_in),
    .alu_enable(alu_enable), .alu_op_code(alu_op_code), .alu_op0(alu_op0), .alu_op1(alu_op1),
    .alu_out(alu_out), .busy(busy), .fsm_state(fsm_state)
`ifdef PROC_ISSUE_PERF_CNT_EN
    , .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // external combinational ALU
  always_comb begin
    case (alu_op_code)
      OP_ADD:  alu_out = alu_op0 + alu_op1;
      OP_SUB:  alu_out = alu_op0 - alu_op1;
      OP_AND:  alu_out = alu_op0 & alu_op1;
      default: alu_out = alu_op0 | alu_op1;
    endcase
  end

  logic [IW-1:0] ctrl_q[$];
  logic [DW-1:0] int_q[$], nin_q[$];
  logic [DW-1:0] nout_got[$], bus_got[$];
  int            int_deq_cyc[$];
  logic          nout_full_f, bus_full_f;
  int            cyc, pop_cyc, nout_cyc, bus_cyc;
  int            ctrl_deq_cnt, int_deq_cnt, nin_deq_cnt;
  logic          strobe_any;
  int            tests, fails;

  typedef struct {
    logic [7:0]    inst;
    int            n_int;
    logic [DW-1:0] i0, i1;
    int            n_nin;
    logic [DW-1:0] n0, n1;
    int            nout_cnt;
    logic [DW-1:0] nout_val;
    int            bus_cnt;
    logic [DW-1:0] bus_val;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive_inputs();
    ctrl_fifo_empty    = (ctrl_q.size() == 0);
    ctrl_fifo_data_out = ctrl_fifo_empty ? '0 : ctrl_q[0];
    int_fifo_empty     = (int_q.size() == 0);
    int_fifo_data_out  = int_fifo_empty ? '0 : int_q[0];
    nin_fifo_empty     = (nin_q.size() == 0);
    nin_fifo_data_out  = nin_fifo_empty ? '0 : nin_q[0];
    nout_fifo_full     = nout_full_f;
    bus_fifo_full      = bus_full_f;
  endtask

  task automatic clear_counts();
    ctrl_deq_cnt = 0; int_deq_cnt = 0; nin_deq_cnt = 0;
    nout_got.delete(); bus_got.delete(); int_deq_cyc.delete();
    pop_cyc = -1; nout_cyc = -1; bus_cyc = -1;
  endtask

  // driver: one clock, sampling strobes mid-cycle and updating FIFO models
  task automatic cycle();
    drive_inputs();
    #1;
    strobe_any = ctrl_fifo_deq | int_fifo_deq | nin_fifo_deq | nout_fifo_enq | bus_fifo_enq;
    if (ctrl_fifo_deq) begin
      ctrl_deq_cnt++; pop_cyc = cyc;
      if (ctrl_q.size() > 0) void'(ctrl_q.pop_front());
    end
    if (int_fifo_deq) begin
      int_deq_cnt++; int_deq_cyc.push_back(cyc);
      if (int_q.size() > 0) void'(int_q.pop_front());
    end
    if (nin_fifo_deq) begin
      nin_deq_cnt++;
      if (nin_q.size() > 0) void'(nin_q.pop_front());
    end
    if (nout_fifo_enq) begin nout_got.push_back(nout_fifo_data_in); nout_cyc = cyc; end
    if (bus_fifo_enq) begin bus_got.push_back(bus_fifo_data_in); bus_cyc = cyc; end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_inst(input int budget, output bit done);
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (ctrl_deq_cnt > 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (fsm_state == st) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic vec_t mk(input logic [7:0] inst, input int ni, input logic [DW-1:0] i0, i1,
                              input int nn, input logic [DW-1:0] n0, n1,
                              input int oc, input logic [DW-1:0] ov, input int bc, input logic [DW-1:0] bv);
    vec_t v;
    v.inst = inst; v.n_int = ni; v.i0 = i0; v.i1 = i1; v.n_nin = nn; v.n0 = n0; v.n1 = n1;
    v.nout_cnt = oc; v.nout_val = ov; v.bus_cnt = bc; v.bus_val = bv;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit done, ok;
    int bad;
    int stall_before;

    tests = 0; fails = 0; cyc = 0;
    nout_full_f = 1'b0; bus_full_f = 1'b0;
    clear_counts();

    // accumulator carries between rows; comments give the acc after each row
    vecs[0] = mk(8'h06, 1, 4'd3, 4'd0, 1, 4'd4, 4'd0, 1, 4'd7, 0, 4'd0);   // ADD int+nin -> nout, acc=7
    vecs[1] = mk(8'h42, 2, 4'd5, 4'd2, 0, 4'd0, 4'd0, 1, 4'd3, 0, 4'd0);   // SUB int,int -> nout, acc=3
    vecs[2] = mk(8'h85, 1, 4'hC, 4'd0, 1, 4'hA, 4'd0, 0, 4'd0, 1, 4'h8);   // AND -> bus, acc=8
    vecs[3] = mk(8'hED, 0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 0, 4'd0, 1, 4'h8);   // OR acc|0 -> bus, acc=8
    vecs[4] = mk(8'h73, 1, 4'd1, 4'd0, 0, 4'd0, 4'd0, 1, 4'hF, 1, 4'hF);   // SUB 0-int -> both, acc=F
    vecs[5] = mk(8'h2A, 0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 1, 4'hE, 0, 4'd0);   // ADD acc+acc wraps, acc=E
    vecs[6] = mk(8'h0C, 1, 4'd6, 4'd0, 0, 4'd0, 4'd0, 0, 4'd0, 0, 4'd0);   // ADD int+0, no dst, acc=6
    vecs[7] = mk(8'hED, 0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 0, 4'd0, 1, 4'd6);   // OR acc|0 -> bus, acc=6
    vecs[8] = mk(8'h56, 0, 4'd0, 4'd0, 2, 4'd7, 4'd3, 1, 4'd4, 0, 4'd0);   // SUB nin,nin -> nout

    // reset with an instruction waiting: nothing may be popped
    reset = 1'b1;
    ctrl_q.push_back(8'h06);
    repeat (3) cycle();
    check("reset_ctrl_deq", ctrl_deq_cnt, 0);
    check("reset_busy", busy, 0);
    check("reset_state", fsm_state, ST_IDLE);
    check("reset_alu_enable", alu_enable, 0);
    check("reset_alu_ops", {alu_op_code, alu_op0, alu_op1}, 0);
    check("reset_data_in", {nout_fifo_data_in, bus_fifo_data_in}, 0);
`ifdef PROC_ISSUE_PERF_CNT_EN
    check("reset_perf", {retired_cnt, stall_cnt}, 0);
`endif
    ctrl_q.delete();
    reset = 1'b0;
    cycle();

    for (int v = 0; v < 9; v++) begin
      clear_counts();
      if (vecs[v].n_int > 0) int_q.push_back(vecs[v].i0);
      if (vecs[v].n_int > 1) int_q.push_back(vecs[v].i1);
      if (vecs[v].n_nin > 0) nin_q.push_back(vecs[v].n0);
      if (vecs[v].n_nin > 1) nin_q.push_back(vecs[v].n1);
      ctrl_q.push_back(vecs[v].inst);
      run_inst(40, done);
      check($sformatf("v%0d_done", v), done, 1);
      check($sformatf("v%0d_ctrl_deq", v), ctrl_deq_cnt, 1);
      check($sformatf("v%0d_int_deq", v), int_deq_cnt, vecs[v].n_int);
      check($sformatf("v%0d_nin_deq", v), nin_deq_cnt, vecs[v].n_nin);
      check($sformatf("v%0d_nout_cnt", v), nout_got.size(), vecs[v].nout_cnt);
      check($sformatf("v%0d_bus_cnt", v), bus_got.size(), vecs[v].bus_cnt);
      if (nout_got.size() > 0) check($sformatf("v%0d_nout_data", v), nout_got[0], vecs[v].nout_val);
      if (bus_got.size() > 0) check($sformatf("v%0d_bus_data", v), bus_got[0], vecs[v].bus_val);
      if (v == 0) check("v0_pop_to_enq", nout_cyc - pop_cyc, 4);
      if (v == 1 && int_deq_cyc.size() == 2) check("v1_int_deq_consecutive", int_deq_cyc[1] - int_deq_cyc[0], 1);
      int_q.delete(); nin_q.delete();
    end

    // empty nin source: hold in FETCH1 with no strobes, then complete
    clear_counts();
    int_q.push_back(4'd2);
    ctrl_q.push_back(8'h06);
    wait_state(ST_FETCH1, 20, ok);
    check("stall_reach_fetch1", ok, 1);
`ifdef PROC_ISSUE_PERF_CNT_EN
    stall_before = int'(stall_cnt);
`else
    stall_before = 0;
`endif
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (strobe_any || fsm_state != ST_FETCH1) bad++;
    end
    check("stall_hold_no_strobe", bad, 0);
`ifdef PROC_ISSUE_PERF_CNT_EN
    check("stall_cnt_delta", int'(stall_cnt) - stall_before, 10);
`endif
    nin_q.push_back(4'd1);
    run_inst(40, done);
    check("stall_done", done, 1);
    check("stall_nout_cnt", nout_got.size(), 1);
    if (nout_got.size() > 0) check("stall_nout_data", nout_got[0], 4'd3);

    // both destinations, bus full for 4 cycles in WRITE
    clear_counts();
    int_q.push_back(4'd2); int_q.push_back(4'd3);
    ctrl_q.push_back(8'h03);
    bus_full_f = 1'b1;
    wait_state(ST_WRITE, 20, ok);
    check("dual_reach_write", ok, 1);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (nout_got.size() != 0 || bus_got.size() != 0 || fsm_state != ST_WRITE) bad++;
    end
    check("dual_no_partial_write", bad, 0);
    bus_full_f = 1'b0;
    cycle();
    check("dual_nout_cnt", nout_got.size(), 1);
    check("dual_bus_cnt", bus_got.size(), 1);
    check("dual_same_cycle", nout_cyc == bus_cyc && nout_cyc >= 0, 1);
    if (nout_got.size() > 0) check("dual_nout_data", nout_got[0], 4'd5);
    if (bus_got.size() > 0) check("dual_bus_data", bus_got[0], 4'd5);
    check("dual_idle_after", busy, 0);

    // reset while in FETCH1 with nin holding data
    clear_counts();
    int_q.push_back(4'd1); nin_q.push_back(4'd2);
    ctrl_q.push_back(8'h06);
    wait_state(ST_FETCH1, 20, ok);
    check("rst_reach_fetch1", ok, 1);
    reset = 1'b1;
    drive_inputs();
    #1;
    check("rst_strobes_low", {ctrl_fifo_deq, int_fifo_deq, nin_fifo_deq, nout_fifo_enq, bus_fifo_enq}, 0);
    @(posedge clk);
    #1;
    cyc++;
    check("rst_busy_next", busy, 0);
    check("rst_state_next", fsm_state, ST_IDLE);
`ifdef PROC_ISSUE_PERF_CNT_EN
    check("rst_perf_zero", {retired_cnt, stall_cnt}, 0);
`endif
    reset = 1'b0;
    int_q.delete(); nin_q.delete(); ctrl_q.delete();
    clear_counts();
    int_q.push_back(4'd4); nin_q.push_back(4'd5);
    ctrl_q.push_back(8'h06);
    run_inst(40, done);
    check("post_rst_done", done, 1);
    check("post_rst_nout_cnt", nout_got.size(), 1);
    if (nout_got.size() > 0) check("post_rst_nout_data", nout_got[0], 4'd9);
`ifdef PROC_ISSUE_PERF_CNT_EN
    check("post_rst_retired", retired_cnt, 1);
    check("post_rst_stall", stall_cnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
